// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 mux stage.
// Grants one requester at a time, rotating after MAX_HOLD cycles unless locked.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       lock,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} st_e;

  localparam logic [HOLD_W-1:0] MAX_C = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] ONE   = HOLD_W'(1);

  st_e               st_q, st_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic [1:0] nxt;
  logic [1:0] win;
  logic [3:0] others;

  // First set bit of r at or above start, wrapping 3 -> 0.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    st_d   = st_q;
    ptr_d  = ptr_q;
    sel_d  = sel_q;
    gnt_d  = gnt_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    nxt    = sel_q + 2'd1;
    win    = 2'd0;
    others = req & ~(4'b0001 << sel_q);
    case (st_q)
      IDLE: begin
        if (|req) begin
          win    = pick(req, ptr_q);
          st_d   = GRANT;
          sel_d  = win;
          gnt_d  = 4'b0001 << win;
          busy_d = 1'b1;
          cnt_d  = ONE;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          // Release wins over timeout; hand off with no idle bubble.
          ptr_d = nxt;
          if (|req) begin
            win   = pick(req, nxt);
            sel_d = win;
            gnt_d = 4'b0001 << win;
            cnt_d = ONE;
          end else begin
            st_d   = IDLE;
            gnt_d  = 4'b0000;
            busy_d = 1'b0;
          end
        end else if (cnt_q < MAX_C) begin
          cnt_d = cnt_q + ONE;
        end else if (!lock) begin
          cnt_d = ONE;
          if (|others) begin
            win   = pick(others, nxt);
            ptr_d = nxt;
            sel_d = win;
            gnt_d = 4'b0001 << win;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      ptr_q  <= 2'd0;
      sel_q  <= 2'd0;
      gnt_q  <= 4'b0000;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      gnt_q  <= gnt_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule
